// File: rtl/alu_md_unit.sv
// Execute-stage unit: combinational ALU plus an iterative radix-2 multiply/divide engine
// writing HI/LO. Define MD_FAST_ZERO_EN to let zero-operand mult/div skip the iteration.
module alu_md_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic [3:0]       i_alu_op,
    output logic [WIDTH-1:0] o_alu_out,
    input  logic             i_md_start,
    input  logic [2:0]       i_md_op,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CntW-1:0]    r_count;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_dividend;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_md_signed;
    logic               w_src1_neg;
    logic               w_src2_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_fast;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH-1:0]   w_div_sub;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    assign w_shamt = i_src1[SHAMT_W-1:0];

    always_comb begin
        o_alu_out = '0;
        case (i_alu_op)
            4'd0:    o_alu_out = i_src1 + i_src2;
            4'd1:    o_alu_out = i_src1 - i_src2;
            4'd2:    o_alu_out = i_src1 | i_src2;
            4'd3:    o_alu_out = i_src1 & i_src2;
            4'd4:    o_alu_out = i_src1 ^ i_src2;
            4'd5:    o_alu_out = ~(i_src1 | i_src2);
            4'd6:    o_alu_out = {{(WIDTH-1){1'b0}}, $signed(i_src1) < $signed(i_src2)};
            4'd7:    o_alu_out = {{(WIDTH-1){1'b0}}, i_src1 < i_src2};
            4'd8:    o_alu_out = i_src2 << w_shamt;
            4'd9:    o_alu_out = i_src2 >> w_shamt;
            4'd10:   o_alu_out = $signed(i_src2) >>> w_shamt;
            default: o_alu_out = '0;
        endcase
    end

    // Signed ops iterate on magnitudes; the sign is restored when the result is written.
    assign w_md_signed = ~i_md_op[0];
    assign w_src1_neg  = w_md_signed & i_src1[WIDTH-1];
    assign w_src2_neg  = w_md_signed & i_src2[WIDTH-1];
    assign w_a_mag     = w_src1_neg ? -i_src1 : i_src1;
    assign w_b_mag     = w_src2_neg ? -i_src2 : i_src2;

`ifdef MD_FAST_ZERO_EN
    assign w_fast = i_md_op[1] ? (i_src2 == '0) : ((i_src1 == '0) || (i_src2 == '0));
`else
    assign w_fast = 1'b0;
`endif

    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ok    = w_div_shift >= {1'b0, r_b};
    // Remainder is always below the divisor, so the difference fits in WIDTH bits.
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;

    always_comb begin
        if (r_is_div) begin
            w_step_hi = w_div_ok ? w_div_sub : w_div_shift[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], w_div_ok};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

    always_comb begin
        w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fin_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_fin_hi = r_dividend;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = w_rem_fix;
                w_fin_lo = w_quo_fix;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_count    <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_b        <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle, StFin: begin
                    r_state <= StIdle;
                    if (i_md_start) begin
                        case (i_md_op)
                            3'd4: r_hi <= i_src1;
                            3'd5: r_lo <= i_src1;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_state    <= StRun;
                                r_is_div   <= i_md_op[1];
                                r_neg_q    <= w_src1_neg ^ w_src2_neg;
                                r_neg_r    <= w_src1_neg;
                                r_div0     <= i_md_op[1] && (i_src2 == '0);
                                r_dividend <= i_src1;
                                r_b        <= w_b_mag;
                                r_acc_hi   <= '0;
                                // Fast path: a zeroed accumulator already is the product.
                                r_acc_lo   <= w_fast ? '0 : w_a_mag;
                                r_busy     <= ~w_fast;
                                r_count    <= w_fast ? CntW'(WIDTH) : '0;
                            end
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    if (r_count == CntW'(WIDTH)) begin
                        r_hi    <= w_fin_hi;
                        r_lo    <= w_fin_lo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StFin;
                    end else begin
                        r_acc_hi <= w_step_hi;
                        r_acc_lo <= w_step_lo;
                        r_count  <= r_count + CntW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit (WIDTH=32): ALU table, scoreboarded mult/div results,
// issue rules around busy/FIN, and reset abort.
module tb_alu_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        md_start;
    logic [2:0]  md_op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    alu_md_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_src1     (src1),
        .i_src2     (src2),
        .i_alu_op   (alu_op),
        .o_alu_out  (alu_out),
        .i_md_start (md_start),
        .i_md_op    (md_op),
        .o_busy     (busy),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   lat_q[$];
    int   total = 0;
    int   bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t md_model(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        exp_t e;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        e = '0;
        case (op)
            3'd0: begin p = sa * sb; e = p; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; e = p; end
            3'd2: begin
                if (b == 0) e = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: begin
                if (b == 0) e = {a, 32'hFFFF_FFFF};
                else e = {a % b, a / b};
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        int l;
        bit zero;
        zero = op[1] ? (b == 0) : (a == 0 || b == 0);
        l = 33;
`ifdef MD_FAST_ZERO_EN
        if (zero) l = 1;
`else
        if (zero) l = 33;
`endif
        return l;
    endfunction

    // Drive one accepted mult/div and push its expected result and latency.
    task automatic md_issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input exp_t e);
        int l;
        l = exp_lat(op, a, b);
        src1 = a;
        src2 = b;
        md_op = op;
        md_start = 1'b1;
        sb_q.push_back(e);
        lat_q.push_back(l);
        tick();
        md_start = 1'b0;
        chk({tag, ".busy_after_accept"}, {31'b0, busy}, (l > 1) ? 32'd1 : 32'd0);
        if (l > 1) begin
            chk({tag, ".hi_stable"}, hi, m_hi);
            chk({tag, ".lo_stable"}, lo, m_lo);
        end
    endtask

    // Count edges after acceptance until done, then pop and compare the scoreboard.
    task automatic md_wait(input string tag, input int already);
        int n;
        bit seen;
        exp_t e;
        int l;
        n = already;
        seen = 1'b0;
        while (!seen && n < 200) begin
            if (n > 0 || already > 0) tick();
            else tick();
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        e = sb_q.pop_front();
        l = lat_q.pop_front();
        chk({tag, ".latency"}, n, l);
        chk({tag, ".busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({tag, ".hi"}, hi, e.hi);
        chk({tag, ".lo"}, lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic mt_write(input logic [2:0] op, input logic [31:0] v);
        src1 = v;
        md_op = op;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        if (op == 3'd4) m_hi = v;
        if (op == 3'd5) m_lo = v;
    endtask

    logic [3:0]  a_op  [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6,
                                4'd8, 4'd9, 4'd10, 4'd13, 4'd15};
    logic [31:0] a_s1  [14] = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_0000, 32'hFF00_FF00,
                                32'hFF00_FF00, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd1, 32'h24, 32'd4, 32'd4, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] a_s2  [14] = '{32'd1, 32'd7, 32'h0000_0F0F, 32'h0FF0_0FF0, 32'h0FF0_0FF0,
                                32'h0FF0_0FF0, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd1,
                                32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] a_exp [14] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'hF0F0_0F0F, 32'h0F00_0F00,
                                32'hF0F0_F0F0, 32'h000F_000F, 32'd1, 32'd0, 32'd0, 32'h10,
                                32'h0800_0000, 32'hF800_0000, 32'd0, 32'd0};

    initial begin
        bit   any;
        logic [31:0] ra, rb;
        reset = 1'b1;
        src1 = '0;
        src2 = '0;
        alu_op = '0;
        md_start = 1'b0;
        md_op = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.done", {31'b0, done}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            alu_op = a_op[i];
            src1 = a_s1[i];
            src2 = a_s2[i];
            #1;
            chk($sformatf("alu[%0d].op%0d", i, a_op[i]), alu_out, a_exp[i]);
        end

        md_issue("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        md_wait("mult", 0);
        chk("done_pulse_one_cycle", {31'b0, done}, 32'd1);
        tick();
        chk("done_pulse_low", {31'b0, done}, 32'd0);
        md_issue("multu", 3'd1, 32'hFFFF_FFFD, 32'd5, {32'h0000_0004, 32'hFFFF_FFF1});
        md_wait("multu", 0);
        md_issue("div", 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        md_wait("div", 0);
        md_issue("divu_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0});
        md_wait("divu_min", 0);
        md_issue("div_by0", 3'd2, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
        md_wait("div_by0", 0);
        md_issue("divu_by0", 3'd3, 32'h8765_4321, 32'd0, {32'h8765_4321, 32'hFFFF_FFFF});
        md_wait("divu_by0", 0);
        md_issue("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        md_wait("div_min_m1", 0);
        md_issue("mult_zero", 3'd0, 32'h0000_1234, 32'd0, '0);
        md_wait("mult_zero", 0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i >= 2) rb = (rb >> $urandom_range(27, 4)) | 32'd1;
            md_issue($sformatf("rand%0d", i), 3'(i), ra, rb, md_model(3'(i), ra, rb));
            md_wait($sformatf("rand%0d", i), 0);
        end

        mt_write(3'd4, 32'h0000_0055);
        chk("mthi.hi", hi, 32'h0000_0055);
        chk("mthi.busy", {31'b0, busy}, 32'd0);
        mt_write(3'd6, 32'hDEAD_BEEF);
        chk("reserved.hi", hi, m_hi);
        chk("reserved.lo", lo, m_lo);
        chk("reserved.busy", {31'b0, busy}, 32'd0);

        // mthi while running is dropped; mtlo in the done cycle is taken.
        md_issue("prot", 3'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        repeat (5) tick();
        src1 = 32'h1234;
        md_op = 3'd4;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        chk("prot.hi_unchanged", hi, m_hi);
        md_wait("prot", 6);
        mt_write(3'd5, 32'h0000_ABCD);
        chk("fin_mtlo.lo", lo, 32'h0000_ABCD);
        chk("fin_mtlo.hi", hi, 32'hFFFF_FFFF);

        md_issue("abort", 3'd2, 32'd1000, 32'd7, '0);
        void'(sb_q.pop_front());
        void'(lat_q.pop_front());
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort.busy", {31'b0, busy}, 32'd0);
        chk("abort.done", {31'b0, done}, 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        any = 1'b0;
        repeat (40) begin
            tick();
            if (done !== 1'b0) any = 1'b1;
        end
        chk("abort.no_done", {31'b0, any}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
